bp_be_regfile_multiwrite: RTL

//  Flop-based integer/FP register file for the dual/multi-issue backend.

---
 rtl/bp_be_regfile_multiwrite_if.sv | 30 +++
 rtl/bp_be_regfile_multiwrite.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/bp_be_regfile_multiwrite_if.sv
// Register file bus: read requests/data for every source port and all writeback ports.
interface bp_be_regfile_multiwrite_if #(
  parameter int data_width_p  = 64,
  parameter int issue_width_p = 2,
  parameter int read_ports_p  = 2,
  parameter int write_ports_p = 2,
  parameter int addr_width_p  = 5
);
  localparam int nr_lp = issue_width_p * read_ports_p;

  logic [nr_lp-1:0]                      rs_r_v_i;
  logic [nr_lp*addr_width_p-1:0]         rs_addr_i;
  logic [nr_lp*data_width_p-1:0]         rs_data_o;
  logic [write_ports_p-1:0]              rd_w_v_i;
  logic [write_ports_p*addr_width_p-1:0] rd_addr_i;
  logic [write_ports_p*data_width_p-1:0] rd_data_i;
  logic                                  w_conflict_o;

  // Issue/writeback side: drives requests and writes, observes read data
  modport master (
    output rs_r_v_i, rs_addr_i, rd_w_v_i, rd_addr_i, rd_data_i,
    input  rs_data_o, w_conflict_o
  );

  // Register file side
  modport slave (
    input  rs_r_v_i, rs_addr_i, rd_w_v_i, rd_addr_i, rd_data_i,
    output rs_data_o, w_conflict_o
  );
endinterface

// File: rtl/bp_be_regfile_multiwrite.sv
// Flop-based multi-ported register file with one-cycle registered reads,
// write-before-read forwarding and per-port held source values that are
// refreshed by later writes to the held address.
module bp_be_regfile_multiwrite #(
  parameter int data_width_p  = 64,
  parameter int issue_width_p = 2,
  parameter int read_ports_p  = 2,
  parameter int write_ports_p = 2,
  parameter bit zero_x0_p     = 1'b1,
  parameter int addr_width_p  = 5
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bp_be_regfile_multiwrite_if.slave bus
);
  localparam int nr_lp  = issue_width_p * read_ports_p;
  localparam int els_lp = 1 << addr_width_p;

  // Storage
  logic [data_width_p-1:0] mem_r [els_lp];

  // Unpacked views of the packed bus fields
  logic [addr_width_p-1:0] rs_addr  [nr_lp];
  logic [addr_width_p-1:0] wr_addr  [write_ports_p];
  logic [data_width_p-1:0] wr_data  [write_ports_p];
  logic                    wr_en    [write_ports_p];

  // Per-port read state: valid_r selects fresh vs held data
  logic [nr_lp-1:0]        valid_r;
  logic [addr_width_p-1:0] addr_r   [nr_lp];
  logic [data_width_p-1:0] fresh_r  [nr_lp];
  logic [data_width_p-1:0] hold_r   [nr_lp];

  logic [data_width_p-1:0] fwd_data  [nr_lp];
  logic [data_width_p-1:0] hold_next [nr_lp];
  logic                    conflict;
  logic                    w_conflict_r;

  // Split packed bus fields; writes to x0 are squashed when x0 is hardwired
  always_comb begin
    for (int i = 0; i < nr_lp; i++) begin
      rs_addr[i] = bus.rs_addr_i[i*addr_width_p +: addr_width_p];
    end
    for (int w = 0; w < write_ports_p; w++) begin
      wr_addr[w] = bus.rd_addr_i[w*addr_width_p +: addr_width_p];
      wr_data[w] = bus.rd_data_i[w*data_width_p +: data_width_p];
      wr_en[w]   = bus.rd_w_v_i[w] && !(zero_x0_p && (wr_addr[w] == '0));
    end
  end

  // Fresh read value: storage, overridden by this cycle's writes (later ports win)
  always_comb begin
    for (int i = 0; i < nr_lp; i++) begin
      fwd_data[i] = mem_r[rs_addr[i]];
      for (int w = 0; w < write_ports_p; w++) begin
        if (wr_en[w] && (wr_addr[w] == rs_addr[i])) begin
          fwd_data[i] = wr_data[w];
        end
      end
      if (zero_x0_p && (rs_addr[i] == '0)) begin
        fwd_data[i] = '0;
      end
    end
  end

  // Held value: currently shown value, refreshed by writes to the held address
  always_comb begin
    for (int i = 0; i < nr_lp; i++) begin
      hold_next[i] = valid_r[i] ? fresh_r[i] : hold_r[i];
      for (int w = 0; w < write_ports_p; w++) begin
        if (wr_en[w] && (wr_addr[w] == addr_r[i])) begin
          hold_next[i] = wr_data[w];
        end
      end
    end
  end

  // Two or more enabled write ports hitting the same register
  always_comb begin
    conflict = 1'b0;
    for (int a = 0; a < write_ports_p; a++) begin
      for (int b = a + 1; b < write_ports_p; b++) begin
        if (wr_en[a] && wr_en[b] && (wr_addr[a] == wr_addr[b])) begin
          conflict = 1'b1;
        end
      end
    end
  end

  // Storage write; ascending port loop makes the highest-index port win
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int e = 0; e < els_lp; e++) begin
        mem_r[e] <= '0;
      end
    end else begin
      for (int w = 0; w < write_ports_p; w++) begin
        if (wr_en[w]) begin
          mem_r[wr_addr[w]] <= wr_data[w];
        end
      end
    end
  end

  // Per-port read capture and hold tracking
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_r <= '0;
      for (int i = 0; i < nr_lp; i++) begin
        addr_r[i]  <= '0;
        fresh_r[i] <= '0;
        hold_r[i]  <= '0;
      end
    end else begin
      valid_r <= bus.rs_r_v_i;
      for (int i = 0; i < nr_lp; i++) begin
        hold_r[i] <= hold_next[i];
        if (bus.rs_r_v_i[i]) begin
          addr_r[i]  <= rs_addr[i];
          fresh_r[i] <= fwd_data[i];
        end
      end
    end
  end

  // Conflict flag is reported for exactly the cycle after the writes
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_conflict_r <= 1'b0;
    end else begin
      w_conflict_r <= conflict;
    end
  end

  // Output select: fresh data right after a request, held data otherwise
  always_comb begin
    bus.rs_data_o = '0;
    for (int i = 0; i < nr_lp; i++) begin
      bus.rs_data_o[i*data_width_p +: data_width_p] = valid_r[i] ? fresh_r[i] : hold_r[i];
    end
    bus.w_conflict_o = w_conflict_r;
  end

endmodule
